// File: rtl/spi_baud_generator_pkg.sv
// SPI baud generator shared definitions: mode codes, divisor width,
// and the SPPR/SPR divisor helper.
package spi_baud_generator_pkg;

  localparam logic [1:0] SPI_RUN  = 2'b00;
  localparam logic [1:0] SPI_WAIT = 2'b01;
  localparam logic [1:0] SPI_STOP = 2'b10;

  localparam int SEL_W = 3;
  localparam int DIV_W = 12;

  // div = (sppr+1) << (spr+1); the shift amount is widened so that
  // spr=7 does not wrap back to a shift of 0.
  function automatic logic [DIV_W-1:0] calc_div(
    input logic [SEL_W-1:0] sppr,
    input logic [SEL_W-1:0] spr
  );
    logic [DIV_W-1:0] base;
    logic [SEL_W:0]   sh;
    base = DIV_W'(sppr) + DIV_W'(1);
    sh   = {1'b0, spr} + (SEL_W+1)'(1);
    return base << sh;
  endfunction

endpackage

// File: rtl/spi_baud_generator_if.sv
// Control/status bundle between the SPI controller (master) and the
// baud generator (slave): mode, prescaler, CPOL/CPHA, ss in; SCLK, flags out.
interface spi_baud_generator_if #(
  parameter int SPPR_W = 3,
  parameter int SPR_W  = 3,
  parameter int DIV_W  = 12
);
  import spi_baud_generator_pkg::*;

  logic [1:0]        spi_mode;
  logic              spiswai;
  logic [SPPR_W-1:0] sppr;
  logic [SPR_W-1:0]  spr;
  logic              cpol;
  logic              cpha;
  logic              ss;
  logic              sclk;
  logic [DIV_W-1:0]  baud_rate_divisor;
  logic              flag_low;
  logic              flag_high;
  logic              flags_low;
  logic              flags_high;

  modport master (
    output spi_mode, spiswai, sppr, spr,
    output cpol, cpha, ss,
    input  sclk, baud_rate_divisor,
    input  flag_low, flag_high,
    input  flags_low, flags_high
  );

  modport slave (
    input  spi_mode, spiswai, sppr, spr,
    input  cpol, cpha, ss,
    output sclk, baud_rate_divisor,
    output flag_low, flag_high,
    output flags_low, flags_high
  );

endinterface

// File: rtl/spi_baud_generator.sv
// SCLK generator: half-period counter plus lead/trail edge FSM.
// Ports: PCLK, PRESETn (async low), bus (slave side of the SPI bundle).
module spi_baud_generator #(
  parameter int SPPR_W = 3,
  parameter int SPR_W  = 3,
  parameter int DIV_W  = 12
) (
  input logic                 PCLK,
  input logic                 PRESETn,
  spi_baud_generator_if.slave bus
);
  import spi_baud_generator_pkg::*;

  localparam int CW = DIV_W - 1;

  localparam logic [1:0] IDLE         = 2'd0;
  localparam logic [1:0] ACTIVE_LEAD  = 2'd1;
  localparam logic [1:0] ACTIVE_TRAIL = 2'd2;

  logic [SPPR_W-1:0] sppr_c;
  logic [SPR_W-1:0]  spr_c;
  logic [DIV_W-1:0]  div_c;

  logic [1:0]       state_q;
  logic [1:0]       nxt_state;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    nxt_cnt;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] half_w;
  logic [DIV_W-1:0] hm1;
  logic [DIV_W-1:0] hm2;
  logic             cpol_q;
  logic             cpha_q;
  logic             sclk_q;
  logic             fl_q;
  logic             fh_q;
  logic             fsl_q;
  logic             fsh_q;

  logic mode_ok;
  logic active;
  logic wrap;
  logic tgl;
  logic fire;
  logic warn;
  logic smp;

  assign sppr_c = bus.sppr;
  assign spr_c  = bus.spr;
  assign div_c  = calc_div(sppr_c, spr_c);

  always_comb begin
    mode_ok = 1'b0;
    unique case (1'b1)
      (bus.spi_mode == SPI_RUN):  mode_ok = 1'b1;
      (bus.spi_mode == SPI_WAIT): mode_ok = !bus.spiswai;
      default:                    mode_ok = 1'b0;
    endcase
  end

  assign active = !bus.ss && mode_ok;

  // Arithmetic kept at DIV_W so half=1024 and half-2 both fit.
  assign half_w = div_q >> 1;
  assign hm1    = half_w - DIV_W'(1);
  assign hm2    = half_w - DIV_W'(2);
  assign wrap   = ({1'b0, cnt_q} == hm1);

  always_comb begin
    nxt_state = IDLE;
    nxt_cnt   = '0;
    tgl       = 1'b0;
    if (active) begin
      unique case (state_q)
        ACTIVE_LEAD, ACTIVE_TRAIL: begin
          if (wrap) begin
            tgl       = 1'b1;
            nxt_state = (state_q == ACTIVE_LEAD)
                      ? ACTIVE_TRAIL : ACTIVE_LEAD;
          end else begin
            nxt_cnt   = cnt_q + CW'(1);
            nxt_state = state_q;
          end
        end
        default: nxt_state = ACTIVE_LEAD;
      endcase
    end
  end

  // Flags are registered from the next count/state so that they are
  // high during the cycle in which the count sits at half-1 / half-2.
  assign fire = ({1'b0, nxt_cnt} == hm1);
  assign warn = (half_w == DIV_W'(1))
              ? fire : ({1'b0, nxt_cnt} == hm2);
  assign smp  = (nxt_state == ACTIVE_LEAD) ^ cpha_q;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= DIV_W'(2);
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      sclk_q  <= 1'b0;
      fl_q    <= 1'b0;
      fh_q    <= 1'b0;
      fsl_q   <= 1'b0;
      fsh_q   <= 1'b0;
    end else begin
      state_q <= nxt_state;
      cnt_q   <= nxt_cnt;
      fsh_q   <= active && fire && smp;
      fsl_q   <= active && fire && !smp;
      fh_q    <= active && warn && smp;
      fl_q    <= active && warn && !smp;
      if (!active) begin
        cpol_q <= bus.cpol;
        cpha_q <= bus.cpha;
        div_q  <= div_c;
        sclk_q <= cpol_q;
      end else if (state_q == IDLE) begin
        sclk_q <= cpol_q;
      end else if (tgl) begin
        sclk_q <= ~sclk_q;
      end
    end
  end

  assign bus.sclk              = sclk_q;
  assign bus.baud_rate_divisor = div_q;
  assign bus.flag_low          = fl_q;
  assign bus.flag_high         = fh_q;
  assign bus.flags_low         = fsl_q;
  assign bus.flags_high        = fsh_q;

endmodule

// File: tb/tb_spi_baud_generator.sv
// Directed bench for spi_baud_generator: reset, divisor table, SCLK and
// flag timing across divisors/modes, aborts and mid-transfer changes.
module tb_spi_baud_generator;
  import spi_baud_generator_pkg::*;

  logic PCLK;
  logic PRESETn;
  int   n_cmp = 0;
  int   n_err = 0;

  spi_baud_generator_if bus ();

  spi_baud_generator dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .bus     (bus)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  function automatic logic [4:0] obs();
    return {bus.sclk, bus.flag_low, bus.flag_high,
            bus.flags_low, bus.flags_high};
  endfunction

  // Expected {sclk, flag_low, flag_high, flags_low, flags_high}
  // k cycles after the edge that first sees the transfer active.
  function automatic logic [4:0] model(
    input int k, input int half,
    input logic pol, input logic pha
  );
    int   c;
    int   m;
    logic lead;
    logic smp;
    logic fire;
    logic warn;
    c    = k % half;
    m    = k / half;
    lead = ((m % 2) == 0);
    smp  = lead ^ pha;
    fire = (c == half - 1);
    warn = (half == 1) ? fire : (c == half - 2);
    return {pol ^ !lead, warn & !smp, warn & smp,
            fire & !smp, fire & smp};
  endfunction

  task automatic setup(
    input logic [2:0] p, input logic [2:0] r,
    input logic pol, input logic pha
  );
    bus.ss       = 1'b1;
    bus.spi_mode = SPI_RUN;
    bus.spiswai  = 1'b0;
    bus.sppr     = p;
    bus.spr      = r;
    bus.cpol     = pol;
    bus.cpha     = pha;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    PRESETn      = 1'b0;
    bus.ss       = 1'b1;
    bus.spi_mode = SPI_RUN;
    bus.spiswai  = 1'b0;
    bus.sppr     = 3'd5;
    bus.spr      = 3'd5;
    bus.cpol     = 1'b1;
    bus.cpha     = 1'b1;
    repeat (3) tick();
    n_cmp++;
    if (obs() !== 5'b00000) begin
      n_err++;
      $display("FAIL reset_outs got=%b want=%b", obs(), 5'b00000);
    end
    n_cmp++;
    if (bus.baud_rate_divisor !== 12'd2) begin
      n_err++;
      $display("FAIL reset_div got=%0d want=2", bus.baud_rate_divisor);
    end
    PRESETn = 1'b1;
    tick();
  endtask

  task automatic test_divisor_table();
    logic [2:0]  tp [7] = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd7, 3'd4, 3'd3};
    logic [2:0]  tr [7] = '{3'd0, 3'd1, 3'd0, 3'd7, 3'd7, 3'd2, 3'd6};
    logic [11:0] te [7] = '{12'd2, 12'd8, 12'd6, 12'd256,
                            12'd2048, 12'd40, 12'd512};
    bus.ss = 1'b1;
    for (int i = 0; i < 7; i++) begin
      bus.sppr = tp[i];
      bus.spr  = tr[i];
      tick();
      n_cmp++;
      if (bus.baud_rate_divisor !== te[i]) begin
        n_err++;
        $display("FAIL div_table i=%0d got=%0d want=%0d",
                 i, bus.baud_rate_divisor, te[i]);
      end
    end
  endtask

  task automatic test_div2();
    setup(3'd0, 3'd0, 1'b0, 1'b0);
    n_cmp++;
    if (bus.baud_rate_divisor !== 12'd2) begin
      n_err++;
      $display("FAIL div2_div got=%0d want=2", bus.baud_rate_divisor);
    end
    bus.ss = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      n_cmp++;
      if (obs() !== model(k, 1, 1'b0, 1'b0)) begin
        n_err++;
        $display("FAIL div2 k=%0d got=%b want=%b",
                 k, obs(), model(k, 1, 1'b0, 1'b0));
      end
    end
    bus.ss = 1'b1;
    tick();
  endtask

  task automatic test_div8_mode0();
    setup(3'd1, 3'd1, 1'b0, 1'b0);
    n_cmp++;
    if (bus.baud_rate_divisor !== 12'd8) begin
      n_err++;
      $display("FAIL div8_div got=%0d want=8", bus.baud_rate_divisor);
    end
    bus.ss = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      n_cmp++;
      if (obs() !== model(k, 4, 1'b0, 1'b0)) begin
        n_err++;
        $display("FAIL div8_m0 k=%0d got=%b want=%b",
                 k, obs(), model(k, 4, 1'b0, 1'b0));
      end
    end
    bus.ss = 1'b1;
    tick();
  endtask

  task automatic test_cpol1_cpha1();
    setup(3'd1, 3'd1, 1'b1, 1'b1);
    n_cmp++;
    if (bus.sclk !== 1'b1) begin
      n_err++;
      $display("FAIL m3_idle got=%b want=1", bus.sclk);
    end
    bus.ss = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      n_cmp++;
      if (obs() !== model(k, 4, 1'b1, 1'b1)) begin
        n_err++;
        $display("FAIL div8_m3 k=%0d got=%b want=%b",
                 k, obs(), model(k, 4, 1'b1, 1'b1));
      end
    end
    bus.ss = 1'b1;
    tick();
  endtask

  task automatic test_ss_abort();
    setup(3'd1, 3'd1, 1'b0, 1'b0);
    bus.ss = 1'b0;
    for (int k = 0; k < 7; k++) begin
      tick();
      n_cmp++;
      if (obs() !== model(k, 4, 1'b0, 1'b0)) begin
        n_err++;
        $display("FAIL abort_pre k=%0d got=%b want=%b",
                 k, obs(), model(k, 4, 1'b0, 1'b0));
      end
    end
    bus.ss = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++;
      if (obs() !== 5'b00000) begin
        n_err++;
        $display("FAIL abort_idle i=%0d got=%b want=00000", i, obs());
      end
    end
    bus.ss = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      n_cmp++;
      if (obs() !== model(k, 4, 1'b0, 1'b0)) begin
        n_err++;
        $display("FAIL abort_re k=%0d got=%b want=%b",
                 k, obs(), model(k, 4, 1'b0, 1'b0));
      end
    end
    bus.ss = 1'b1;
    tick();
  endtask

  task automatic test_wait_stop();
    setup(3'd1, 3'd1, 1'b1, 1'b0);
    bus.spi_mode = SPI_WAIT;
    bus.spiswai  = 1'b1;
    bus.ss       = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_cmp++;
      if (obs() !== 5'b10000) begin
        n_err++;
        $display("FAIL wait_held i=%0d got=%b want=10000", i, obs());
      end
    end
    bus.spiswai = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      n_cmp++;
      if (obs() !== model(k, 4, 1'b1, 1'b0)) begin
        n_err++;
        $display("FAIL wait_run k=%0d got=%b want=%b",
                 k, obs(), model(k, 4, 1'b1, 1'b0));
      end
    end
    bus.spi_mode = SPI_STOP;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if (obs() !== 5'b10000) begin
        n_err++;
        $display("FAIL stop10 i=%0d got=%b want=10000", i, obs());
      end
    end
    bus.spi_mode = 2'b11;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++;
      if (obs() !== 5'b10000) begin
        n_err++;
        $display("FAIL stop11 i=%0d got=%b want=10000", i, obs());
      end
    end
    bus.spi_mode = SPI_WAIT;
    for (int k = 0; k < 6; k++) begin
      tick();
      n_cmp++;
      if (obs() !== model(k, 4, 1'b1, 1'b0)) begin
        n_err++;
        $display("FAIL wait_run2 k=%0d got=%b want=%b",
                 k, obs(), model(k, 4, 1'b1, 1'b0));
      end
    end
    bus.spiswai = 1'b1;
    tick();
    n_cmp++;
    if (obs() !== 5'b10000) begin
      n_err++;
      $display("FAIL swai_abort got=%b want=10000", obs());
    end
    bus.ss       = 1'b1;
    bus.spi_mode = SPI_RUN;
    bus.spiswai  = 1'b0;
    tick();
  endtask

  task automatic test_midchange();
    setup(3'd1, 3'd1, 1'b0, 1'b0);
    bus.ss = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      n_cmp++;
      if (obs() !== model(k, 4, 1'b0, 1'b0) ||
          bus.baud_rate_divisor !== 12'd8) begin
        n_err++;
        $display("FAIL mid_frozen k=%0d got=%b/%0d want=%b/8",
                 k, obs(), bus.baud_rate_divisor,
                 model(k, 4, 1'b0, 1'b0));
      end
      if (k == 3) bus.spr = 3'd3;
      if (k == 5) bus.cpol = 1'b1;
    end
    bus.ss = 1'b1;
    repeat (2) tick();
    n_cmp++;
    if (bus.baud_rate_divisor !== 12'd32) begin
      n_err++;
      $display("FAIL mid_newdiv got=%0d want=32", bus.baud_rate_divisor);
    end
    bus.ss = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      n_cmp++;
      if (obs() !== model(k, 16, 1'b1, 1'b0)) begin
        n_err++;
        $display("FAIL mid_div32 k=%0d got=%b want=%b",
                 k, obs(), model(k, 16, 1'b1, 1'b0));
      end
    end
    bus.ss = 1'b1;
    tick();
  endtask

  task automatic test_max_div();
    setup(3'd7, 3'd7, 1'b0, 1'b1);
    n_cmp++;
    if (bus.baud_rate_divisor !== 12'd2048) begin
      n_err++;
      $display("FAIL max_div got=%0d want=2048", bus.baud_rate_divisor);
    end
    bus.ss = 1'b0;
    for (int k = 0; k < 1031; k++) begin
      tick();
      n_cmp++;
      if (obs() !== model(k, 1024, 1'b0, 1'b1)) begin
        n_err++;
        $display("FAIL max_run k=%0d got=%b want=%b",
                 k, obs(), model(k, 1024, 1'b0, 1'b1));
      end
    end
    bus.ss = 1'b1;
    tick();
  endtask

  task automatic test_async_reset();
    setup(3'd1, 3'd1, 1'b0, 1'b0);
    bus.ss = 1'b0;
    repeat (6) tick();
    n_cmp++;
    if (obs() !== 5'b10000) begin
      n_err++;
      $display("FAIL arst_pre got=%b want=10000", obs());
    end
    #2;
    PRESETn = 1'b0;
    #1;
    n_cmp++;
    if (obs() !== 5'b00000 || bus.baud_rate_divisor !== 12'd2) begin
      n_err++;
      $display("FAIL arst_now got=%b/%0d want=00000/2",
               obs(), bus.baud_rate_divisor);
    end
    repeat (2) tick();
    bus.ss  = 1'b1;
    PRESETn = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_divisor_table();
    test_div2();
    test_div8_mode0();
    test_cpol1_cpha1();
    test_ss_abort();
    test_wait_stop();
    test_midchange();
    test_max_div();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spi_baud_generator.md
Name: spi_baud_generator

Overview:
- Upstream neighbour of the SPI shift register in the APB SPI master.
- Derives SCLK from PCLK using the SPPR/SPR prescaler fields.
- Drives SCLK idle/active per CPOL, and produces the one-cycle pre-edge pulses (flag_low/flag_high/flags_low/flags_high) that time shift-out and MISO sampling.
- Runs only while a transfer is active (ss low) and the SPI mode allows it.

Parameters:
- SPPR_W, 3, width of the baud prescaler select field
- SPR_W, 3, width of the baud rate select field
- DIV_W, 12, width of the divisor output; must hold (2^SPPR_W)*2^(2^SPR_W) = 2048

Ports:
- PCLK  input  1  system clock
- PRESETn  input  1  asynchronous active-low reset
- spi_mode  input  2  00 run, 01 wait, 10/11 stop
- spiswai  input  1  1 = stop SCLK in wait mode
- sppr  input  3  prescaler select
- spr  input  3  rate select
- cpol  input  1  SCLK idle level
- cpha  input  1  0 = sample on leading edge, 1 = sample on trailing edge
- ss  input  1  active-low slave select from the controller
- sclk  output  1  SPI serial clock
- baud_rate_divisor  output  DIV_W  current divisor, (sppr+1)<<(spr+1)
- flag_low  output  1  early warning, one cycle before flags_low
- flag_high  output  1  early warning, one cycle before flags_high
- flags_low  output  1  pulse in the PCLK cycle before a shift (drive) edge
- flags_high  output  1  pulse in the PCLK cycle before a sample edge

Behaviour:
- One clock, PCLK. Reset is asynchronous and active-low on PRESETn.
- All outputs are registered.
- Reset values: sclk=0, baud_rate_divisor=2, all flags=0, half-period counter=0, latched cpol/cpha/divisor=0/0/2.
- Divisor arithmetic: div = (sppr+1) << (spr+1), DIV_W bits, range 2..2048. half = div>>1, range 1..1024. The counter is DIV_W-1 bits wide. No overflow is possible.
- Enable: active = !ss && (spi_mode==00 || (spi_mode==01 && !spiswai)).
- Idle (active=0):
  - cpol, cpha and div are re-latched every cycle.
  - sclk is driven to the latched cpol on the next cycle.
  - The counter is held at 0.
  - All flags are 0.
- Active:
  - Latched cpol, cpha and div are frozen. sppr/spr/cpol/cpha changes mid-transfer have no effect until idle.
  - The counter increments every cycle. When it reaches half-1, it wraps to 0 and sclk toggles at the next PCLK edge.
- Edge classification:
  - Leading edge = sclk leaving the cpol level. Trailing edge = sclk returning to it.
  - Sample edge = leading edge if cpha=0, trailing edge if cpha=1. Shift edge = the other one.
- Flag timing:
  - flags_high is 1 in exactly the cycle where count==half-1 and the upcoming toggle is a sample edge.
  - flags_low is the same condition for a shift edge.
  - flag_high/flag_low are 1 where count==half-2 with the same edge classification.
  - When half==1, flag_* equals flags_* in the same cycle. There is no earlier cycle.
  - flags_low and flags_high are never both 1 in one cycle.
- First edge: ss falls in cycle T (sampled at edge T). The counter reaches half-1 at cycle T+half, so the first sclk toggle is visible at T+half+1.
- Deactivation mid-period (ss rises, mode change, or spiswai set in wait mode):
  - Takes effect the next cycle.
  - Counter goes to 0, flags go to 0, sclk returns to cpol. No partial pulse is completed.
- Re-activation restarts from count 0.
- Reset mid-transfer forces reset values immediately. Asynchronous assertion, synchronous release.
- baud_rate_divisor always reflects the latched divisor.

Decomposition:
- spi_pkg holds:
  - mode encodings SPI_RUN=2'b00, SPI_WAIT=2'b01, SPI_STOP=2'b10
  - DIV_W
  - a function computing the divisor from sppr/spr
- No sub-module. The block is one counter plus an edge-classification FSM with states IDLE, ACTIVE_LEAD (next toggle is leading) and ACTIVE_TRAIL (next toggle is trailing).

Test Plan:
- sppr=0, spr=0, cpol=0, cpha=0, ss low in run mode -> divisor=2, sclk toggles every cycle, flags_high/flags_low alternate every cycle starting with flags_high, flag_* equals flags_*.
- sppr=1, spr=1, cpol=0, cpha=0 -> divisor=8, sclk period 8 PCLK; flag_high at count 2, flags_high at count 3, then a rising sclk edge; flags_low precedes each falling edge.
- cpol=1, cpha=1, divisor 8 -> sclk idles high; the first flags_low precedes the first falling (leading) edge, and flags_high precedes each rising edge.
- ss raised 2 cycles into a half-period (divisor 8) -> next cycle counter=0, sclk=cpol, no flags; ss low again -> first toggle half+1 cycles later.
- spi_mode=01, spiswai=1 with ss low -> sclk held at cpol, no flags; spiswai=0 -> clocking resumes. spi_mode=10 -> always idle.
- Change spr from 1 to 3 while active -> period stays 8 until ss rises; after re-entry divisor=32 and sclk period is 32.
